// File: rtl/note_player.sv
// Note sequencer: latches a note/duration, looks up its phase step, then advances a
// 22-bit phase accumulator on sample ticks until the beat count for the note runs out.

module frequency_rom (
    input  logic        clk,
    input  logic [5:0]  addr,
    output logic [19:0] dout
);
    logic [5:0]  index;
    logic [3:0]  semitone;
    logic [2:0]  octave;
    logic [19:0] base;

    // Lowest-octave steps for a 48 kHz sample rate; higher octaves are power-of-two shifts.
    always_comb begin
        index    = addr - 6'd1;
        semitone = 4'(index % 6'd12);
        octave   = 3'(index / 6'd12);
        // NOTE: the default arm gives base a value on every path, so no latch is inferred.
        case (semitone)
            4'd0:    base = 20'd2858;
            4'd1:    base = 20'd3028;
            4'd2:    base = 20'd3208;
            4'd3:    base = 20'd3398;
            4'd4:    base = 20'd3600;
            4'd5:    base = 20'd3815;
            4'd6:    base = 20'd4041;
            4'd7:    base = 20'd4282;
            4'd8:    base = 20'd4536;
            4'd9:    base = 20'd4806;
            4'd10:   base = 20'd5092;
            4'd11:   base = 20'd5394;
            default: base = 20'd0;
        endcase
    end

    // NOTE: this register only holds a ROM read, so it carries no reset.
    always_ff @(posedge clk) begin
        dout <= (addr == 6'd0) ? 20'd0 : (base << octave);
    end
endmodule

module note_player (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic        new_note,
    input  logic [5:0]  note,
    input  logic [5:0]  duration,
    input  logic        beat,
    input  logic        sample_ready,
    output logic        note_done,
    output logic [21:0] phase,
    output logic        active
);
    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

    state_t      state;
    logic [5:0]  note_q;
    logic [5:0]  duration_q;
    logic [5:0]  remaining;
    logic [19:0] step_q;
    logic [19:0] rom_dout;
    logic [5:0]  rom_addr;
    logic        start;

    assign start = new_note && play;

    // Present the incoming note on the accepting edge so its step is ready by the end of LOAD.
    assign rom_addr = start ? note : note_q;

    frequency_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .dout (rom_dout)
    );

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            note_q     <= 6'd0;
            duration_q <= 6'd0;
            remaining  <= 6'd0;
            step_q     <= 20'd0;
            phase      <= 22'd0;
            note_done  <= 1'b0;
            active     <= 1'b0;
        end else begin
            note_done <= 1'b0;
            if (start) begin
                // A new note aborts whatever is in flight, including a pending IDLE return from DONE.
                note_q     <= note;
                duration_q <= duration;
                state      <= LOAD;
                active     <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                    end
                    LOAD: begin
                        if (play) begin
                            step_q    <= (note_q == 6'd0) ? 20'd0 : rom_dout;
                            remaining <= duration_q;
                            phase     <= 22'd0;
                            if (duration_q == 6'd0) begin
                                state     <= DONE;
                                note_done <= 1'b1;
                            end else begin
                                state  <= PLAY;
                                active <= (note_q != 6'd0);
                            end
                        end
                    end
                    PLAY: begin
                        if (play) begin
                            // A rest has a zero step, so its phase stays at zero.
                            if (sample_ready) begin
                                phase <= phase + {2'b00, step_q};
                            end
                            if (beat) begin
                                remaining <= remaining - 6'd1;
                                if (remaining == 6'd1) begin
                                    state     <= DONE;
                                    note_done <= 1'b1;
                                    active    <= 1'b0;
                                end
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player: an abstract per-edge note model checked every cycle,
// plus hand-computed literal expectations for each scenario.

module tb_note_player;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        play = 1'b0;
    logic        new_note = 1'b0;
    logic [5:0]  note = 6'd0;
    logic [5:0]  duration = 6'd0;
    logic        beat = 1'b0;
    logic        sample_ready = 1'b0;
    logic        note_done;
    logic [21:0] phase;
    logic        active;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;

    always #5 clk = ~clk;

    note_player dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .new_note     (new_note),
        .note         (note),
        .duration     (duration),
        .beat         (beat),
        .sample_ready (sample_ready),
        .note_done    (note_done),
        .phase        (phase),
        .active       (active)
    );

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Phase steps of the notes this bench plays.
    function automatic longint step_of(input int n);
        case (n)
            0:       return 0;
            1:       return 2858;
            12:      return 5394;
            25:      return 11432;
            63:      return 102656;
            default: return -1;
        endcase
    endfunction

    // Model: a note is either absent, waiting one enabled cycle for its step, or sounding.
    bit     m_valid, m_loading, m_done, m_fin, m_ready;
    int     m_note, m_dur, m_left;
    longint m_phase;

    always @(posedge clk) begin
        if (!reset) begin
            m_valid = 0; m_loading = 0; m_done = 0;
            m_note = 0; m_dur = 0; m_left = 0; m_phase = 0;
        end else begin
            m_fin = 0;
            if (new_note && play) begin
                m_valid = 1; m_loading = 1; m_note = note; m_dur = duration;
            end else if (m_valid && play) begin
                if (m_loading) begin
                    m_loading = 0;
                    m_phase = 0;
                    m_left = m_dur;
                    if (m_left == 0) begin
                        m_valid = 0; m_fin = 1;
                    end
                end else begin
                    if (sample_ready && m_note != 0)
                        m_phase = (m_phase + step_of(m_note)) % 4194304;
                    if (beat) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_valid = 0; m_fin = 1;
                        end
                    end
                end
            end
            m_done = m_fin;
        end
        m_ready = 1;
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("note_done", note_done, m_done);
            check("active", active, m_valid && !m_loading && m_note != 0);
            check("phase", phase, m_phase);
            if (note_done) done_pulses++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Presents a note for one edge; returns with the DUT in LOAD.
    task automatic start_note(input logic [5:0] n, input logic [5:0] d);
        note = n;
        duration = d;
        new_note = 1'b1;
        cyc();
        new_note = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int act_cycles;
        int done_at;
        int base_pulses;

        play = 1'b1;
        repeat (3) cyc();
        check("reset_phase", phase, 0);
        check("reset_active", active, 0);
        check("reset_note_done", note_done, 0);

        // Reset beats a simultaneous new_note.
        note = 6'd12; duration = 6'd3; new_note = 1'b1;
        cyc();
        reset = 1'b1; new_note = 1'b0;
        cyc(); cyc();
        check("reset_priority_active", active, 0);

        // new_note while paused is ignored.
        play = 1'b0;
        start_note(6'd12, 6'd3);
        play = 1'b1;
        cyc(); cyc();
        check("paused_new_note_ignored", active, 0);

        // Three beats, ten cycles apart.
        act_cycles = 0; done_at = -1; base_pulses = done_pulses;
        start_note(6'd12, 6'd3);
        cyc();
        act_cycles += int'(active);
        for (int i = 0; i < 30; i++) begin
            beat = (i % 10 == 9);
            cyc();
            act_cycles += int'(active);
            if (note_done) done_at = i;
        end
        beat = 1'b0;
        repeat (3) cyc();
        check("beat3_done_edge", done_at, 29);
        check("beat3_active_cycles", act_cycles, 30);
        check("beat3_pulse_count", done_pulses - base_pulses, 1);

        // Five sample ticks on note 12.
        start_note(6'd12, 6'd2);
        cyc();
        for (int k = 0; k < 5; k++) begin
            sample_ready = 1'b1; cyc();
            sample_ready = 1'b0; cyc();
        end
        check("five_samples_phase", phase, 26970);
        beat = 1'b1; cyc();
        beat = 1'b0; cyc();
        beat = 1'b1; cyc();
        check("two_beat_done", note_done, 1);
        beat = 1'b0; cyc();

        // Wrap on note 63, then final beat coinciding with a sample tick.
        start_note(6'd63, 6'd1);
        cyc();
        sample_ready = 1'b1;
        repeat (41) cyc();
        check("phase_wrap", phase, 14592);
        beat = 1'b1; cyc();
        check("final_beat_phase", phase, 117248);
        check("final_beat_done", note_done, 1);
        beat = 1'b0; sample_ready = 1'b0; cyc();

        // Zero-length note.
        sample_ready = 1'b1;
        start_note(6'd25, 6'd0);
        check("zero_len_load_no_done", note_done, 0);
        cyc();
        check("zero_len_done", note_done, 1);
        check("zero_len_phase", phase, 0);
        sample_ready = 1'b0; cyc();
        check("zero_len_single_pulse", note_done, 0);

        // Rest of two beats.
        start_note(6'd0, 6'd2);
        cyc();
        sample_ready = 1'b1;
        repeat (3) cyc();
        check("rest_phase", phase, 0);
        check("rest_active", active, 0);
        beat = 1'b1; cyc();
        beat = 1'b0; cyc();
        check("rest_not_early", note_done, 0);
        beat = 1'b1; cyc();
        check("rest_done", note_done, 1);
        beat = 1'b0; sample_ready = 1'b0; cyc();

        // Pause for 20 cycles mid-note.
        start_note(6'd1, 6'd3);
        cyc();
        sample_ready = 1'b1;
        repeat (3) cyc();
        sample_ready = 1'b0;
        beat = 1'b1; cyc();
        beat = 1'b0;
        check("pre_pause_phase", phase, 8574);
        base_pulses = done_pulses;
        play = 1'b0;
        for (int i = 0; i < 20; i++) begin
            beat = (i % 2 == 0);
            sample_ready = (i % 3 == 0);
            cyc();
        end
        beat = 1'b0; sample_ready = 1'b0;
        check("paused_phase", phase, 8574);
        check("paused_no_done", done_pulses - base_pulses, 0);
        play = 1'b1;
        cyc();
        beat = 1'b1; cyc();
        beat = 1'b0;
        check("resume_not_early", note_done, 0);
        cyc();
        beat = 1'b1; cyc();
        check("resume_done", note_done, 1);
        beat = 1'b0; cyc();

        // Abort mid-PLAY, reset during the new note, then replay and relaunch from DONE.
        base_pulses = done_pulses;
        start_note(6'd12, 6'd5);
        cyc();
        sample_ready = 1'b1;
        repeat (2) cyc();
        sample_ready = 1'b0;
        start_note(6'd25, 6'd4);
        check("abort_active", active, 0);
        cyc();
        sample_ready = 1'b1; cyc();
        sample_ready = 1'b0;
        check("second_note_phase", phase, 11432);
        beat = 1'b1; cyc();
        beat = 1'b0; reset = 1'b0;
        cyc();
        check("mid_reset_phase", phase, 0);
        check("mid_reset_active", active, 0);
        check("mid_reset_note_done", note_done, 0);
        check("aborted_no_done", done_pulses - base_pulses, 0);
        reset = 1'b1;
        cyc();
        start_note(6'd12, 6'd1);
        cyc();
        beat = 1'b1; cyc();
        beat = 1'b0;
        check("after_reset_done", note_done, 1);
        start_note(6'd1, 6'd1);
        check("relaunch_load_no_done", note_done, 0);
        cyc();
        check("relaunch_active", active, 1);
        beat = 1'b1; cyc();
        beat = 1'b0;
        check("relaunch_done", note_done, 1);
        cyc();
        check("tail_pulse_count", done_pulses - base_pulses, 2);

        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001: clk  input  1  -- single clock; all state changes on its rising edge.
REQ-002: reset  input  1  -- synchronous, active-low; registers clear on the clk edge where reset==0.
REQ-003: play  input  1  -- 1 = playback enabled; 0 = freeze all counting/accumulation.
REQ-004: new_note  input  1  -- one-cycle strobe; note/duration valid in the same cycle.
REQ-005: note  input  6  -- note index; 0 = rest, 1..63 = pitch.
REQ-006: duration  input  6  -- note length in beats; 0 = zero-length note.
REQ-007: beat  input  1  -- one-cycle tick marking one beat period.
REQ-008: sample_ready  input  1  -- one-cycle tick requesting the next sample phase.
REQ-009: note_done  output  1  -- one-cycle pulse when the current note's duration expires.
REQ-010: phase  output  22  -- phase accumulator, wraps modulo 2^22.
REQ-011: active  output  1  -- 1 while a non-rest note is sounding (state PLAY, note!=0).

Function
REQ-012: SHALL instantiate the existing frequency_rom (addr 6 bits = latched note, dout 20-bit step, one-cycle registered read latency).
REQ-013: SHALL implement a 4-state FSM: IDLE, LOAD, PLAY, DONE.
REQ-014: IDLE: new_note==1 && play==1 -> latch note, duration; go LOAD. new_note while play==0 is ignored.
REQ-015: LOAD: exactly one cycle, waiting for ROM; latches step; loads remaining=duration; clears phase to 0; go PLAY, or DONE if duration==0.
REQ-016: PLAY: on beat==1 && play==1, remaining decrements by 1; on the decrement from 1 to 0 go DONE in the same edge.
REQ-017: PLAY: on sample_ready==1 && play==1, phase <= phase + {2'b00, step}, truncated to 22 bits (wrap, no saturation).
REQ-018: Rest (latched note==0): step forced to 0, phase held at 0, active==0; duration still counted normally.
REQ-019: DONE: note_done==1 for exactly one cycle; next state IDLE regardless of play.
REQ-020: new_note==1 && play==1 while in LOAD or PLAY: abort current note, latch new values, go LOAD; no note_done for the aborted note.
REQ-021: new_note==1 in DONE: note_done still pulses; new note latched and FSM goes LOAD instead of IDLE.
REQ-022: play==0 in LOAD/PLAY: state, remaining, phase frozen; beat and sample_ready ignored; resume on play==1 from the same values.
REQ-023: beat and sample_ready in the same cycle: both take effect; a phase update on the final beat edge is applied before entering DONE.
REQ-024: latency new_note -> first phase update eligibility: 2 cycles (IDLE->LOAD->PLAY).
REQ-025: note_done SHALL never assert for more than one consecutive cycle.

Reset
REQ-026: reset==0 at a clk edge: state=IDLE, note_done=0, phase=0, active=0, remaining=0, latched note/step=0.
REQ-027: reset mid-note: note abandoned, no note_done pulse; next new_note after reset==1 plays normally.
REQ-028: reset has priority over every other input in the same cycle.

Verification
REQ-029: play=1, new_note with note=12, duration=3, beat every 10 cycles -> note_done pulses once, on the edge of the 3rd beat after PLAY entry; active=1 throughout PLAY.
REQ-030: note=12, step from ROM S, 5 sample_ready pulses -> phase = 5*S mod 2^22; step forcing phase past 2^22-1 wraps.
REQ-031: duration=0 -> note_done pulses 2 cycles after new_note (IDLE->LOAD->DONE); phase stays 0.
REQ-032: note=0, duration=2 -> active=0, phase=0, note_done after 2 beats.
REQ-033: play dropped for 20 cycles mid-note with beats/sample_ready toggling -> remaining and phase unchanged; completion delayed accordingly.
REQ-034: second new_note mid-PLAY, then reset==0 during the new note -> no note_done for either; all outputs 0 the cycle after reset.
